// File: rtl/toggle_cover_collector.sv
// Toggle-cover event receiver: latches first hits per bit and streams each newly
// covered global index exactly once over a valid/ready interface, lowest index first.
module toggle_cover_collector #(
   parameter int WIDTH       = 39,
   parameter int COVER_INDEX = 0,
   parameter int COVER_TOTAL = 8065,
   parameter int IDX_W       = $clog2(COVER_TOTAL),
   parameter int CNT_W       = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] valid,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic [CNT_W-1:0] covered_count,
   output logic             all_covered
);

   if (COVER_INDEX + WIDTH - 1 >= COVER_TOTAL) begin : g_range_check
      $error("toggle_cover_collector: COVER_INDEX + WIDTH - 1 exceeds COVER_TOTAL");
   end

   logic [WIDTH-1:0] hit;
   logic [WIDTH-1:0] pend;
   logic [WIDTH-1:0] new_bits;
   logic [WIDTH-1:0] hit_next;
   logic [WIDTH-1:0] load_mask;
   logic [IDX_W-1:0] sel_index;
   logic [CNT_W-1:0] new_count;
   logic             stage_free;
   logic             pend_any;

   always_comb begin
      new_bits   = valid & ~hit;
      hit_next   = hit | new_bits;
      stage_free = !out_valid || out_ready;
      pend_any   = |pend;
      load_mask  = '0;
      sel_index  = '0;
      // Scan high-to-low so the last match left standing is the lowest pending bit.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pend[i]) begin
            load_mask    = '0;
            load_mask[i] = 1'b1;
            sel_index    = IDX_W'(COVER_INDEX) + IDX_W'(i);
         end
      end
      if (!stage_free) begin
         load_mask = '0;
      end
      new_count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         new_count = new_count + CNT_W'(new_bits[i]);
      end
   end

   // Loaded bits are already in hit, so clearing them never collides with new_bits.
   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         hit           <= '0;
         pend          <= '0;
         out_valid     <= 1'b0;
         out_index     <= '0;
         covered_count <= '0;
         all_covered   <= 1'b0;
      end else begin
         hit           <= hit_next;
         pend          <= (pend & ~load_mask) | new_bits;
         covered_count <= covered_count + new_count;
         all_covered   <= &hit_next;
         if (stage_free) begin
            out_valid <= pend_any;
            if (pend_any) begin
               out_index <= sel_index;
            end
         end
      end
   end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Scoreboard bench for toggle_cover_collector: a set-based model of first hits
// feeds an expected-index queue that a negedge monitor drains on every transfer.
module tb_toggle_cover_collector;
   localparam int WIDTH = 39;
   localparam int CI    = 100;
   localparam int IDX_W = 13;
   localparam int CNT_W = 6;

   logic             clock = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] valid;
   logic             clear;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_index;
   logic [CNT_W-1:0] covered_count;
   logic             all_covered;

   toggle_cover_collector #(.WIDTH(WIDTH), .COVER_INDEX(CI), .COVER_TOTAL(8065)) dut (
      .clock(clock), .reset(reset), .valid(valid), .clear(clear),
      .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
      .covered_count(covered_count), .all_covered(all_covered)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int ntransfer = 0;
   int exp_q[$];
   logic [WIDTH-1:0] mhit;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // One clock edge; the model absorbs this edge's inputs, then inputs may change.
   task automatic cyc();
      @(posedge clock);
      if (!reset || clear) begin
         mhit = '0;
         exp_q.delete();
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (valid[i] && !mhit[i]) begin
               mhit[i] = 1'b1;
               exp_q.push_back(CI + i);
            end
         end
      end
      #1;
   endtask

   // Monitor: transfers must match an outstanding expected index; stalls must hold.
   initial begin : monitor
      logic             prev_stall;
      logic [IDX_W-1:0] prev_index;
      int               pos;
      prev_stall = 1'b0;
      prev_index = '0;
      forever begin
         @(negedge clock);
         if (prev_stall) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_index", longint'(out_index), longint'(prev_index));
         end
         prev_stall = reset && !clear && out_valid && !out_ready;
         prev_index = out_index;
         if (reset && !clear && out_valid && out_ready) begin
            ntransfer++;
            pos = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
               if (pos < 0 && exp_q[k] == int'(out_index)) pos = k;
            end
            checks++;
            if (pos < 0) begin
               failures++;
               $display("FAIL xfer_unexpected actual=%0d required=an outstanding new index",
                        out_index);
            end else begin
               exp_q.delete(pos);
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int idx3[3];
      int n0;
      int cyc_n;
      logic [63:0] r;
      mhit = '0;
      reset = 1'b0; clear = 1'b0; valid = '1; out_ready = 1'b0;
      #1;
      cyc(); cyc();
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_count", longint'(covered_count), 0);
      chk("rst_all_covered", longint'(all_covered), 0);
      chk("rst_out_index", longint'(out_index), 0);

      // Single hit latency.
      reset = 1'b1; valid = '0; out_ready = 1'b1;
      cyc();
      valid[5] = 1'b1;
      cyc();
      valid = '0;
      chk("lat_e0_valid", longint'(out_valid), 0);
      chk("lat_e0_count", longint'(covered_count), 1);
      cyc();
      chk("lat_e1_valid", longint'(out_valid), 1);
      chk("lat_e1_index", longint'(out_index), 105);
      cyc();
      chk("lat_e2_valid", longint'(out_valid), 0);

      // Three simultaneous hits go out lowest first, back to back.
      clear = 1'b1; cyc(); clear = 1'b0;
      valid[0] = 1'b1; valid[3] = 1'b1; valid[38] = 1'b1;
      cyc();
      valid = '0;
      chk("multi_count", longint'(covered_count), 3);
      idx3 = '{100, 103, 138};
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("multi_valid", longint'(out_valid), 1);
         chk("multi_index", longint'(out_index), idx3[k]);
      end
      cyc();
      chk("multi_done", longint'(out_valid), 0);

      // Backpressure with repeated hits of the same bit.
      clear = 1'b1; cyc(); clear = 1'b0;
      out_ready = 1'b0;
      valid[7] = 1'b1;
      cyc();
      valid = '0;
      cyc();
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_index", longint'(out_index), 107);
      n0 = ntransfer;
      for (int k = 0; k < 10; k++) begin
         valid = '0;
         if (k % 2 == 0 && k < 8) valid[7] = 1'b1;
         cyc();
         chk("bp_stall_index", longint'(out_index), 107);
      end
      valid = '0; out_ready = 1'b1;
      cyc();
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("bp_no_repeat", longint'(out_valid), 0);
      end
      chk("bp_one_xfer", longint'(ntransfer - n0), 1);
      chk("bp_count", longint'(covered_count), 1);

      // Random hits and random ready until every bit is reported.
      clear = 1'b1; cyc(); clear = 1'b0;
      n0 = ntransfer;
      cyc_n = 0;
      while (cyc_n < 3000 && !(mhit == '1 && exp_q.size() == 0)) begin
         r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         valid = r[WIDTH-1:0];
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
         cyc_n++;
      end
      valid = '0; out_ready = 1'b1;
      cyc(); cyc();
      chk("rand_xfers", longint'(ntransfer - n0), WIDTH);
      chk("rand_drained", longint'(exp_q.size()), 0);
      chk("rand_all_covered", longint'(all_covered), 1);
      chk("rand_count", longint'(covered_count), WIDTH);
      chk("rand_idle", longint'(out_valid), 0);

      // Clear in the middle of a stalled handshake.
      clear = 1'b1; cyc(); clear = 1'b0;
      out_ready = 1'b0;
      valid[10] = 1'b1; valid[11] = 1'b1;
      cyc();
      valid = '0;
      cyc();
      chk("clr_pre_index", longint'(out_index), 110);
      chk("clr_pre_count", longint'(covered_count), 2);
      clear = 1'b1; cyc(); clear = 1'b0;
      chk("clr_valid", longint'(out_valid), 0);
      chk("clr_count", longint'(covered_count), 0);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("clr_quiet", longint'(out_valid), 0);
      end
      valid[10] = 1'b1;
      cyc();
      valid = '0;
      cyc();
      chk("clr_rehit_valid", longint'(out_valid), 1);
      chk("clr_rehit_index", longint'(out_index), 110);
      cyc();

      // Reset with work pending; nothing stale afterwards.
      out_ready = 1'b0;
      valid[25:20] = '1;
      cyc();
      valid = '0;
      cyc(); cyc();
      reset = 1'b0;
      cyc(); cyc();
      chk("mrst_valid", longint'(out_valid), 0);
      chk("mrst_index", longint'(out_index), 0);
      chk("mrst_count", longint'(covered_count), 0);
      chk("mrst_all", longint'(all_covered), 0);
      reset = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk("mrst_no_stale", longint'(out_valid), 0);
      end
      chk("final_drained", longint'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
